ifetch: RTL and testbench

//  Instruction fetch front end. Replaces the fixed-instruction stimulus driving decode.

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/gen_fifo.sv | 60 ++++++
 rtl/ifetch.sv | 131 +++++++++++++
 tb/tb_ifetch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types for the instruction fetch front end
package ifetch_pkg;

    localparam int FE_XLEN = 32;

    typedef logic [31:0] t_rv_instr;

    typedef enum logic [0:0] {
        FE_RUN   = 1'b0,
        FE_DRAIN = 1'b1
    } t_fe_state;

    typedef struct packed {
        t_rv_instr            instr;
        logic [FE_XLEN-1:0]   pc;
    } t_fetch_pkt;

endpackage

// File: rtl/gen_fifo.sv
// rtl/gen_fifo.sv - generic synchronous FIFO with flush, count, empty and full
module gen_fifo #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  T                             push_data,
    input  logic                         pop,
    output T                             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Explicit wrap keeps non-power-of-2 depths correct.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - sequential instruction fetch with credit-based request issue and redirect flush
module ifetch
    import ifetch_pkg::*;
#(
    parameter int              XLEN      = FE_XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_vld,
    input  logic            imem_req_rdy,
    output logic [XLEN-1:0] imem_req_pc,
    input  logic            imem_rsp_vld,
    input  t_rv_instr       imem_rsp_instr,
    input  logic            redirect_vld,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            valid_de0,
    input  logic            ready_de0,
    output t_rv_instr       instr_de0,
    output logic [XLEN-1:0] pc_de0
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(MAX_OUTST + 1);

    t_fe_state       state;
    t_fe_state       state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_nxt;
    logic [CW-1:0]   q_count;
    logic            q_empty;
    logic            q_full;
    t_fetch_pkt      q_head;
    t_fetch_pkt      q_in;
    logic [PW-1:0]   pcq_count;
    logic            pcq_empty;
    logic            pcq_full;
    logic [XLEN-1:0] pcq_head;
    logic            credit_ok;
    logic            fire;
    logic            rsp_push;
    logic            deq;

    // Reserving queue space for every in-flight response means a push never finds the queue full.
    assign credit_ok = (({1'b0, outstanding} + {1'b0, q_count}) < (CW+1)'(DEPTH)) &&
                       (outstanding < CW'(MAX_OUTST));

    assign imem_req_vld = !reset && (state == FE_RUN) && !redirect_vld && credit_ok;
    assign imem_req_pc  = fetch_pc;
    assign fire         = imem_req_vld && imem_req_rdy;
    assign rsp_push     = imem_rsp_vld && (state == FE_RUN) && !redirect_vld;
    assign deq          = valid_de0 && ready_de0 && !redirect_vld;

    assign outstanding_nxt = outstanding + CW'(fire) - CW'(imem_rsp_vld);

    always_comb begin
        state_nxt = state;
        if (redirect_vld || (state == FE_DRAIN)) begin
            state_nxt = (outstanding_nxt != '0) ? FE_DRAIN : FE_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FE_RUN;
            outstanding <= '0;
            fetch_pc    <= RESET_PC;
        end else begin
            state       <= state_nxt;
            outstanding <= outstanding_nxt;
            if (redirect_vld) begin
                fetch_pc <= redirect_pc & ~XLEN'(3);
            end else if (fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
        end
    end

    gen_fifo #(
        .T     (logic [XLEN-1:0]),
        .DEPTH (MAX_OUTST)
    ) u_pc_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_vld),
        .push      (fire),
        .push_data (fetch_pc),
        .pop       (rsp_push),
        .pop_data  (pcq_head),
        .count     (pcq_count),
        .empty     (pcq_empty),
        .full      (pcq_full)
    );

    assign q_in.instr = imem_rsp_instr;
    assign q_in.pc    = pcq_head;

    gen_fifo #(
        .T     (t_fetch_pkt),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_vld),
        .push      (rsp_push),
        .push_data (q_in),
        .pop       (deq),
        .pop_data  (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    assign valid_de0 = !q_empty;
    assign instr_de0 = q_head.instr;
    assign pc_de0    = q_head.pc;

    // Protocol invariants: responses only for issued requests, and the PC FIFO tracks them in FE_RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(imem_rsp_vld && (outstanding == '0)));
            assert (!(rsp_push && (q_full || pcq_empty)));
            assert (!(fire && pcq_full));
            assert ((state != FE_RUN) || (pcq_count == PW'(outstanding)));
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed self-checking bench for ifetch
module tb_ifetch;

    logic        clk;
    logic        reset;
    logic        imem_req_vld;
    logic        imem_req_rdy;
    logic [31:0] imem_req_pc;
    logic        imem_rsp_vld;
    logic [31:0] imem_rsp_instr;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        valid_de0;
    logic        ready_de0;
    logic [31:0] instr_de0;
    logic [31:0] pc_de0;

    int          n_checks;
    int          n_errors;
    int          cyc;
    int          lat;
    int          n_fire;
    int          stall_bad;
    int          instr_bad;
    logic        prev_stall;
    logic [31:0] stall_pc;
    logic [31:0] obs[$];
    logic [31:0] mem_pc[$];
    int          mem_due[$];

    ifetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_vld   (imem_req_vld),
        .imem_req_rdy   (imem_req_rdy),
        .imem_req_pc    (imem_req_pc),
        .imem_rsp_vld   (imem_rsp_vld),
        .imem_rsp_instr (imem_rsp_instr),
        .redirect_vld   (redirect_vld),
        .redirect_pc    (redirect_pc),
        .valid_de0      (valid_de0),
        .ready_de0      (ready_de0),
        .instr_de0      (instr_de0),
        .pc_de0         (pc_de0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 with inputs set; returns at the next posedge+1 with memory outputs driven.
    task automatic tick();
        logic        fire;
        logic        deq;
        logic [31:0] fpc;
        #2;
        if (prev_stall === 1'b1 && imem_req_vld === 1'b1 && imem_req_pc !== stall_pc) stall_bad++;
        prev_stall = imem_req_vld && !imem_req_rdy;
        stall_pc   = imem_req_pc;
        fire = imem_req_vld && imem_req_rdy;
        fpc  = imem_req_pc;
        deq  = valid_de0 && ready_de0 && !redirect_vld && !reset;
        if (deq === 1'b1) begin
            obs.push_back(pc_de0);
            if (instr_de0 !== ~pc_de0) instr_bad++;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (reset) begin
            mem_pc.delete();
            mem_due.delete();
        end else if (fire === 1'b1) begin
            mem_pc.push_back(fpc);
            mem_due.push_back(cyc + lat - 1);
            n_fire++;
        end
        if (mem_pc.size() > 0 && mem_due[0] <= cyc) begin
            imem_rsp_vld   = 1'b1;
            imem_rsp_instr = ~mem_pc[0];
            void'(mem_pc.pop_front());
            void'(mem_due.pop_front());
        end else begin
            imem_rsp_vld   = 1'b0;
            imem_rsp_instr = '0;
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        imem_req_rdy = 1'b1;
        redirect_vld = 1'b0;
        redirect_pc  = '0;
        ready_de0    = 1'b0;
        tick();
        tick();
        check("rst_req_vld", imem_req_vld, 0);
        check("rst_valid_de0", valid_de0, 0);
        reset     = 1'b0;
        obs.delete();
        n_fire    = 0;
        cyc       = 0;
        stall_bad = 0;
        #1;
    endtask

    task automatic run_until(input int n);
        for (int i = 0; i < 60 && obs.size() < n; i++) tick();
        check("obs_count", obs.size() >= n, 1);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; lat = 1; n_fire = 0;
        stall_bad = 0; instr_bad = 0; prev_stall = 1'b0; stall_pc = '0;
        reset = 1'b1; imem_req_rdy = 1'b1; imem_rsp_vld = 1'b0; imem_rsp_instr = '0;
        redirect_vld = 1'b0; redirect_pc = '0; ready_de0 = 1'b0;
        @(posedge clk);
        #1;

        // 1: back-to-back stream, latency 1
        lat = 1;
        do_reset();
        ready_de0 = 1'b1;
        check("t1_first_req_vld", imem_req_vld, 1);
        check("t1_first_req_pc", imem_req_pc, 32'h0);
        for (int i = 0; i < 10 && !valid_de0; i++) tick();
        check("t1_first_valid_edge", cyc, 2);
        for (int i = 0; i < 6; i++) tick();
        check("t1_b2b_count", obs.size(), 6);
        for (int i = 0; i < obs.size() && i < 6; i++) check("t1_pc", obs[i], 32'(4 * i));

        // 2: decode stalled, queue fills to DEPTH
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        #1;
        check("t2_fires", n_fire, 4);
        check("t2_req_vld", imem_req_vld, 0);
        check("t2_valid_held", valid_de0, 1);
        check("t2_head_pc", pc_de0, 32'h0);
        ready_de0 = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("t2_no_gap_count", obs.size(), 8);
        for (int i = 0; i < obs.size() && i < 8; i++) check("t2_pc", obs[i], 32'(4 * i));

        // 3: imem_req_rdy toggling
        do_reset();
        ready_de0 = 1'b1;
        for (int i = 0; i < 24; i++) begin
            imem_req_rdy = (cyc % 2 == 0);
            tick();
        end
        check("t3_stall_pc_stable", stall_bad, 0);
        check("t3_min_count", obs.size() >= 5, 1);
        for (int i = 0; i < obs.size(); i++) check("t3_pc", obs[i], 32'(4 * i));
        imem_req_rdy = 1'b1;

        // 4: redirect with two requests in flight, latency 3
        lat = 3;
        do_reset();
        ready_de0 = 1'b1;
        tick();
        tick();
        redirect_vld = 1'b1;
        redirect_pc  = 32'h100;
        tick();
        redirect_vld = 1'b0;
        #1;
        check("t4_drain_no_req", imem_req_vld, 0);
        check("t4_flushed", valid_de0, 0);
        run_until(2);
        check("t4_pc0", obs[0], 32'h100);
        check("t4_pc1", obs[1], 32'h104);

        // 5: redirect to unaligned 0x203 with nothing in flight, during a dequeue
        lat = 1;
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        ready_de0    = 1'b1;
        redirect_vld = 1'b1;
        redirect_pc  = 32'h203;
        tick();
        redirect_vld = 1'b0;
        #1;
        check("t5_flushed", valid_de0, 0);
        check("t5_req_vld", imem_req_vld, 1);
        check("t5_req_pc", imem_req_pc, 32'h200);
        run_until(2);
        check("t5_pc0", obs[0], 32'h200);
        check("t5_pc1", obs[1], 32'h204);

        // 6: PC wrap, then reset mid-stream
        do_reset();
        ready_de0    = 1'b1;
        redirect_vld = 1'b1;
        redirect_pc  = 32'hFFFF_FFFC;
        tick();
        redirect_vld = 1'b0;
        #1;
        check("t6_req_pc_top", imem_req_pc, 32'hFFFF_FFFC);
        tick();
        check("t6_req_pc_wrap", imem_req_pc, 32'h0);
        run_until(3);
        check("t6_pc0", obs[0], 32'hFFFF_FFFC);
        check("t6_pc1", obs[1], 32'h0);
        check("t6_pc2", obs[2], 32'h4);
        reset = 1'b1;
        tick();
        check("t6_rst_req_vld", imem_req_vld, 0);
        check("t6_rst_valid", valid_de0, 0);
        reset = 1'b0;
        obs.delete();
        #1;
        check("t6_restart_pc", imem_req_pc, 32'h0);
        run_until(2);
        check("t6_restart_pc0", obs[0], 32'h0);
        check("t6_restart_pc1", obs[1], 32'h4);

        check("instr_matches_pc", instr_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
